// File: rtl/cpu_types_pkg.sv
// Shared CPU fetch types: machine word and fetch FSM state encoding.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    HOLD   = 2'd1,
    HALTED = 2'd2
  } fetch_state_t;

  localparam word_t PC_STEP = 32'd4;

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch: PC, FETCH/HOLD/HALTED FSM; zero-latency imem-to-latch path, stall refetches or (FETCH_SKID_EN) parks the word in a one-entry skid buffer.
// Priority each cycle: redirect > halt > ihit/stall; HALTED is left only through nRST.
module fetch_unit
  import cpu_types_pkg::*;
#(
  parameter logic [31:0] PC_INIT = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        ihit,
  input  logic [31:0] imemload,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        halt,
  output logic        imemREN,
  output logic [31:0] imemaddr,
  output logic [31:0] instr_out,
  output logic [31:0] pc_plus_4_out,
  output logic        instr_valid,
  output logic        halted
);

  fetch_state_t state_q, state_d;
  word_t        pc_q, pc_d;
  word_t        pc_plus_4;
  word_t        redirect_aligned;
  logic         valid_d;
`ifdef FETCH_SKID_EN
  word_t        buf_instr_q, buf_instr_d;
  word_t        buf_pc4_q, buf_pc4_d;
`endif

  assign pc_plus_4        = pc_q + PC_STEP;
  assign redirect_aligned = redirect_pc & ~32'd3;

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    valid_d       = 1'b0;
    instr_out     = imemload;
    pc_plus_4_out = pc_plus_4;
`ifdef FETCH_SKID_EN
    buf_instr_d   = buf_instr_q;
    buf_pc4_d     = buf_pc4_q;
`endif
    case (state_q)
      FETCH: begin
        if (redirect_valid) begin
          pc_d = redirect_aligned;
        end else if (halt) begin
          state_d = HALTED;
        end else if (ihit && !stall) begin
          valid_d = 1'b1;
          pc_d    = pc_plus_4;
        end else if (ihit) begin
`ifdef FETCH_SKID_EN
          // Park the word so imem can move on while the latch is blocked
          buf_instr_d = imemload;
          buf_pc4_d   = pc_plus_4;
          pc_d        = pc_plus_4;
          state_d     = HOLD;
`endif
        end
      end
`ifdef FETCH_SKID_EN
      HOLD: begin
        instr_out     = buf_instr_q;
        pc_plus_4_out = buf_pc4_q;
        if (redirect_valid) begin
          pc_d        = redirect_aligned;
          buf_instr_d = '0;
          buf_pc4_d   = '0;
          state_d     = FETCH;
        end else if (halt) begin
          state_d = HALTED;
        end else begin
          valid_d = 1'b1;
          if (!stall) state_d = FETCH;
        end
      end
`endif
      HALTED: begin
        state_d = HALTED;
      end
      default: begin
        state_d = FETCH;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q     <= FETCH;
      pc_q        <= PC_INIT;
`ifdef FETCH_SKID_EN
      buf_instr_q <= '0;
      buf_pc4_q   <= '0;
`endif
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
`ifdef FETCH_SKID_EN
      buf_instr_q <= buf_instr_d;
      buf_pc4_q   <= buf_pc4_d;
`endif
    end
  end

  // Latch enable must stay low while reset is held, even if imem reports a hit
  assign instr_valid = valid_d & nRST;
  assign imemREN     = (state_q == FETCH);
  assign imemaddr    = pc_q;
  assign halted      = (state_q == HALTED);

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: scoreboard of expected {instr, pc+4} pairs popped whenever instr_valid is seen.
module tb_fetch_unit;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        ihit;
  logic [31:0] imemload;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halt;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic [31:0] instr_out;
  logic [31:0] pc_plus_4_out;
  logic        instr_valid;
  logic        halted;

  int passed = 0;
  int total  = 0;
  int failed = 0;

  logic [63:0] sb[$];
  logic [31:0] exp_pc;
  logic [31:0] cap_w;

  fetch_unit #(.PC_INIT(32'h0000_0000)) dut (
    .CLK            (CLK),
    .nRST           (nRST),
    .ihit           (ihit),
    .imemload       (imemload),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halt           (halt),
    .imemREN        (imemREN),
    .imemaddr       (imemaddr),
    .instr_out      (instr_out),
    .pc_plus_4_out  (pc_plus_4_out),
    .instr_valid    (instr_valid),
    .halted         (halted)
  );

  always #5 CLK = ~CLK;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'hC0DE, ~a[31:16]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic h, input logic s, input logic rv,
                       input logic [31:0] rpc, input logic hl);
    ihit           = h;
    stall          = s;
    redirect_valid = rv;
    redirect_pc    = rpc;
    halt           = hl;
    imemload       = mem_word(exp_pc);
  endtask

  task automatic expect_fetch();
    sb.push_back({mem_word(exp_pc), exp_pc + 32'd4});
  endtask

  // Checks outputs mid-cycle, then advances to just after the next rising edge
  task automatic cycle(input string tag, input logic exp_valid);
    logic [63:0] e;
    #2;
    chk1({tag, ".valid"}, instr_valid, exp_valid);
    if (instr_valid === 1'b1) begin
      if (sb.size() == 0) begin
        total++;
        failed++;
        $error("FAIL %s.sb: observed unexpected instr %h expected no instruction", tag, instr_out);
      end else begin
        e = sb.pop_front();
        chk({tag, ".instr"}, instr_out, e[63:32]);
        chk({tag, ".pc4"}, pc_plus_4_out, e[31:0]);
      end
    end
    @(posedge CLK);
    #1;
  endtask

  initial begin
    nRST = 1'b0; ihit = 1'b1; stall = 1'b0; redirect_valid = 1'b0;
    redirect_pc = 32'h0; halt = 1'b0; exp_pc = 32'h0; imemload = 32'h1234_5678;
    #3;
    chk1("rst.imemREN", imemREN, 1'b1);
    chk("rst.imemaddr", imemaddr, 32'h0);
    chk1("rst.valid", instr_valid, 1'b0);
    chk1("rst.halted", halted, 1'b0);
    chk("rst.instr_out", instr_out, 32'h1234_5678);
    @(negedge CLK);
    nRST = 1'b1;

    // Back-to-back hits: 0,4,8,12
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
      chk("seq.addr", imemaddr, exp_pc);
      expect_fetch();
      cycle("seq", 1'b1);
      exp_pc = exp_pc + 32'd4;
    end

    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    cycle("miss", 1'b0);
    chk("miss.addr", imemaddr, 32'h10);

    // Stall with a hit pending at 0x10 for three cycles, then release
`ifdef FETCH_SKID_EN
    cap_w = mem_word(exp_pc);
    drive(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
    cycle("skid.cap", 1'b0);
    exp_pc = exp_pc + 32'd4;
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
      chk1("skid.imemREN", imemREN, 1'b0);
      sb.push_back({cap_w, 32'h14});
      cycle("skid.hold", 1'b1);
    end
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    sb.push_back({cap_w, 32'h14});
    cycle("skid.rel", 1'b1);
    chk("skid.addr", imemaddr, 32'h14);
    chk1("skid.imemREN2", imemREN, 1'b1);
`else
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
      cycle("nosk.stall", 1'b0);
      chk("nosk.addr", imemaddr, 32'h10);
      chk1("nosk.imemREN", imemREN, 1'b1);
    end
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    expect_fetch();
    cycle("nosk.rel", 1'b1);
    exp_pc = exp_pc + 32'd4;
    chk("nosk.addr2", imemaddr, 32'h14);
`endif

    // Redirect beats halt and ihit in the same cycle; low bits are cleared
    drive(1'b1, 1'b0, 1'b1, 32'h0000_0103, 1'b1);
    cycle("redir", 1'b0);
    exp_pc = 32'h100;
    chk("redir.addr", imemaddr, 32'h100);
    chk1("redir.halted", halted, 1'b0);
    chk1("redir.imemREN", imemREN, 1'b1);

`ifdef FETCH_SKID_EN
    drive(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
    cycle("hold.enter", 1'b0);
    exp_pc = exp_pc + 32'd4;
    drive(1'b1, 1'b0, 1'b1, 32'h0000_0200, 1'b0);
    chk1("hold.imemREN", imemREN, 1'b0);
    cycle("hold.redir", 1'b0);
    exp_pc = 32'h200;
    chk("hold.redir.addr", imemaddr, 32'h200);
    chk1("hold.redir.imemREN", imemREN, 1'b1);
`endif

    // PC+4 wraps at the top of the address space
    drive(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0);
    cycle("wrap.redir", 1'b0);
    exp_pc = 32'hFFFF_FFFC;
    chk("wrap.addr", imemaddr, 32'hFFFF_FFFC);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    chk("wrap.pc4", pc_plus_4_out, 32'h0);
    expect_fetch();
    cycle("wrap", 1'b1);
    exp_pc = 32'h0;
    chk("wrap.next", imemaddr, 32'h0);

    // Halt at 0x20; later redirect is ignored
    drive(1'b0, 1'b0, 1'b1, 32'h0000_0020, 1'b0);
    cycle("halt.redir", 1'b0);
    exp_pc = 32'h20;
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    cycle("halt", 1'b0);
    chk1("halt.halted", halted, 1'b1);
    chk1("halt.imemREN", imemREN, 1'b0);
    chk("halt.addr", imemaddr, 32'h20);
    drive(1'b1, 1'b0, 1'b1, 32'h0000_0040, 1'b0);
    cycle("halted.redir", 1'b0);
    chk("halted.addr", imemaddr, 32'h20);
    chk1("halted.halted", halted, 1'b1);

    // Asynchronous reset pulse out of HALTED
    nRST = 1'b0;
    #1;
    chk("arst.addr", imemaddr, 32'h0);
    chk1("arst.halted", halted, 1'b0);
    chk1("arst.imemREN", imemREN, 1'b1);
    chk1("arst.valid", instr_valid, 1'b0);
    #1;
    nRST = 1'b1;
    exp_pc = 32'h0;
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    expect_fetch();
    cycle("post_rst", 1'b1);
    exp_pc = exp_pc + 32'd4;
    chk("post_rst.addr", imemaddr, 32'h4);

    chk("sb.drain", 32'(sb.size()), 32'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter PC_INIT, default 32'h0000_0000: PC value after reset.
REQ-002 CLK  input  1  clock, rising-edge.
REQ-003 nRST  input  1  reset, asynchronous, active-low.
REQ-004 ihit  input  1  imem read data valid this cycle.
REQ-005 imemload  input  32  instruction word from imem.
REQ-006 stall  input  1  downstream fetch latch not accepting (hazard unit).
REQ-007 redirect_valid  input  1  branch/jump/flush resolved downstream.
REQ-008 redirect_pc  input  32  new fetch address.
REQ-009 halt  input  1  halt instruction decoded.
REQ-010 imemREN  output  1  imem read enable.
REQ-011 imemaddr  output  32  imem address (current PC).
REQ-012 instr_out  output  32  instruction to fetch latch.
REQ-013 pc_plus_4_out  output  32  PC+4 of instr_out.
REQ-014 instr_valid  output  1  instr_out/pc_plus_4_out valid; drives fetch latch enable.
REQ-015 halted  output  1  fetch permanently stopped.

Function
REQ-016 States SHALL be FETCH, HOLD, HALTED; reset state FETCH.
REQ-017 imemaddr SHALL equal PC; imemREN SHALL be 1 in FETCH, 0 in HOLD and HALTED.
REQ-018 Priority each cycle SHALL be redirect_valid > halt > ihit/stall.
REQ-019 Any state except HALTED, redirect_valid=1: PC <= {redirect_pc[31:2],2'b00}, instr_valid=0, buffer dropped, next state FETCH.
REQ-020 FETCH/HOLD, halt=1 with no redirect: next state HALTED, PC holds, instr_valid=0.
REQ-021 FETCH, ihit=1, stall=0: instr_out=imemload, pc_plus_4_out=PC+4, instr_valid=1, PC <= PC+4 (zero latency, combinational path).
REQ-022 FETCH, ihit=0: instr_valid=0, PC holds.
REQ-023 PC+4 SHALL wrap modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000).
REQ-024 HOLD: instr_out=buffered word, pc_plus_4_out=buffered PC+4, instr_valid=1; stall=0 -> next FETCH; stall=1 -> remain HOLD.
REQ-025 HALTED: halted=1, imemREN=0, instr_valid=0; exit only by reset; redirect and halt ignored.
REQ-026 ihit in HOLD/HALTED SHALL be ignored.

Reset
REQ-027 nRST low SHALL asynchronously force PC=PC_INIT, state FETCH, buffer=0, buffered PC+4=0.
REQ-028 Outputs during reset: imemREN=1, imemaddr=PC_INIT, instr_valid=0, halted=0, instr_out=imemload.
REQ-029 Reset mid-HOLD or mid-HALTED SHALL discard all state; no instruction re-emitted.

Configuration
REQ-030 Macro FETCH_SKID_EN defined: FETCH, ihit=1, stall=1 captures imemload and PC+4 into buffer, PC <= PC+4, next HOLD.
REQ-031 FETCH_SKID_EN undefined: FETCH, ihit=1, stall=1 discards word, PC holds (refetch), HOLD state and buffer absent; instr_valid=0 whenever stall=1.

Structure
REQ-032 word_t (32-bit) and fetch_state_t enum (FETCH, HOLD, HALTED) SHALL live in cpu_types_pkg.
REQ-033 No sub-module; PC register, FSM and skid buffer in one module, single always_ff plus combinational output logic.

Verification
REQ-034 Reset PC_INIT=0, ihit=1 every cycle, stall=0 -> imemaddr 0,4,8,...; instr_valid=1 each cycle; pc_plus_4_out=4,8,12.
REQ-035 FETCH_SKID_EN, ihit=1, stall=1 for 3 cycles at PC=0x10 -> HOLD, imemREN=0, instr_out=word@0x10, pc_plus_4_out=0x14 held; stall drop -> next imemaddr=0x14.
REQ-036 No FETCH_SKID_EN, same stimulus -> imemaddr stays 0x10, instr_valid=0 until stall=0.
REQ-037 redirect_valid=1, redirect_pc=0x0000_0103 with halt=1, ihit=1 same cycle -> instr_valid=0, next imemaddr=0x100, state FETCH.
REQ-038 halt=1 at PC=0x20 -> halted=1, imemREN=0 next cycle; later redirect_valid ignored; nRST pulse -> imemaddr=PC_INIT, halted=0.
REQ-039 PC=32'hFFFF_FFFC, ihit=1, stall=0 -> pc_plus_4_out=0, next imemaddr=0.
